// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : vga_scanout
// Brief    : 800x600@60 VGA scan-out that reads one framebuffer pixel per 4x4 screen block.
//            Optional colour-bar generator enabled by the VGA_TESTPAT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scanout #(
    parameter int   H_VIS      = 800,
    parameter int   H_FP       = 40,
    parameter int   H_SYNC     = 128,
    parameter int   H_BP       = 88,
    parameter int   V_VIS      = 600,
    parameter int   V_FP       = 1,
    parameter int   V_SYNC     = 4,
    parameter int   V_BP       = 23,
    parameter int   SCALE_LOG2 = 2,
    parameter logic SYNC_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef VGA_TESTPAT_EN
    input  logic        test_mode,
`endif
    output logic        read,
    output logic [7:0]  X,
    output logic [7:0]  Y,
    input  logic [11:0] DATIN,
    output logic        wr_ok,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam logic [10:0] c_H_LAST   = 11'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  c_V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] c_H_VIS    = 11'(H_VIS);
    localparam logic [9:0]  c_V_VIS    = 10'(V_VIS);
    localparam logic [10:0] c_HS_START = 11'(H_VIS + H_FP);
    localparam logic [10:0] c_HS_END   = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  c_VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0]  c_VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [10:0] c_BLK_MASK = 11'((1 << SCALE_LOG2) - 1);

    // r_hc/r_vc run one clock ahead of the position that read/X/Y report.
    logic [10:0] r_hc;
    logic [9:0]  r_vc;
    logic        w_vis;
    logic        w_blk;
    logic        w_hs;
    logic        w_vs;
    logic        w_fs;
    logic        w_tm;
    logic        w_issue;

    logic        r_hs_a, r_vs_a, r_blank_a, r_fs_a;
    logic        r_hs_d1, r_vs_d1, r_blank_d1, r_fs_d1, r_read_d1;
    logic        r_hs_d2, r_vs_d2, r_blank_d2, r_fs_d2;
    logic [11:0] r_pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (r_hc == c_H_LAST) begin
            r_hc <= '0;
            r_vc <= (r_vc == c_V_LAST) ? '0 : r_vc + 10'd1;
        end else begin
            r_hc <= r_hc + 11'd1;
        end
    end

    assign w_vis   = (r_hc < c_H_VIS) && (r_vc < c_V_VIS);
    assign w_blk   = (r_hc & c_BLK_MASK) == 11'd0;
    assign w_hs    = (r_hc >= c_HS_START) && (r_hc < c_HS_END);
    assign w_vs    = (r_vc >= c_VS_START) && (r_vc < c_VS_END);
    assign w_fs    = (r_hc == 11'd0) && (r_vc == 10'd0);
    assign w_issue = w_vis && w_blk && !w_tm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read       <= 1'b0;
            X          <= '0;
            Y          <= '0;
            r_hs_a     <= 1'b0;
            r_vs_a     <= 1'b0;
            r_blank_a  <= 1'b1;
            r_fs_a     <= 1'b0;
            r_hs_d1    <= 1'b0;
            r_vs_d1    <= 1'b0;
            r_blank_d1 <= 1'b1;
            r_fs_d1    <= 1'b0;
            r_read_d1  <= 1'b0;
            r_hs_d2    <= 1'b0;
            r_vs_d2    <= 1'b0;
            r_blank_d2 <= 1'b1;
            r_fs_d2    <= 1'b0;
            r_pix      <= '0;
        end else begin
            read <= w_issue;
            if (w_issue) begin
                X <= 8'(r_hc >> SCALE_LOG2);
                Y <= 8'(r_vc >> SCALE_LOG2);
            end
            r_hs_a     <= w_hs;
            r_vs_a     <= w_vs;
            r_blank_a  <= !w_vis;
            r_fs_a     <= w_fs;
            r_hs_d1    <= r_hs_a;
            r_vs_d1    <= r_vs_a;
            r_blank_d1 <= r_blank_a;
            r_fs_d1    <= r_fs_a;
            r_read_d1  <= read;
            r_hs_d2    <= r_hs_d1;
            r_vs_d2    <= r_vs_d1;
            r_blank_d2 <= r_blank_d1;
            r_fs_d2    <= r_fs_d1;
            // Framebuffer data is only valid the cycle after a read; hold otherwise.
            if (r_read_d1) begin
                r_pix <= DATIN;
            end
        end
    end

`ifdef VGA_TESTPAT_EN
    logic        r_tm;
    logic [2:0]  w_bar_idx;
    logic [11:0] w_bar_rgb;
    logic        r_tp_a, r_tp_d1, r_tp_d2;
    logic [11:0] r_bar_a, r_bar_d1, r_bar_d2;

    // Mode is latched on the edge entering the first pixel, so it only changes per frame.
    assign w_tm      = w_fs ? test_mode : r_tm;
    assign w_bar_idx = 3'(r_hc[9:0] / 10'd100);
    assign w_bar_rgb = {{4{w_bar_idx[2]}}, {4{w_bar_idx[1]}}, {4{w_bar_idx[0]}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tm     <= 1'b0;
            r_tp_a   <= 1'b0;
            r_tp_d1  <= 1'b0;
            r_tp_d2  <= 1'b0;
            r_bar_a  <= '0;
            r_bar_d1 <= '0;
            r_bar_d2 <= '0;
        end else begin
            r_tm     <= w_tm;
            r_tp_a   <= w_tm;
            r_tp_d1  <= r_tp_a;
            r_tp_d2  <= r_tp_d1;
            r_bar_a  <= w_bar_rgb;
            r_bar_d1 <= r_bar_a;
            r_bar_d2 <= r_bar_d1;
        end
    end

    assign rgb = r_blank_d2 ? 12'h000 : (r_tp_d2 ? r_bar_d2 : r_pix);
`else
    assign w_tm = 1'b0;
    assign rgb  = r_blank_d2 ? 12'h000 : r_pix;
`endif

    assign wr_ok       = ~read;
    assign hsync       = r_hs_d2 ? SYNC_POL : ~SYNC_POL;
    assign vsync       = r_vs_d2 ? SYNC_POL : ~SYNC_POL;
    assign frame_start = r_fs_d2;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scanout
// Brief    : Self-checking bench for vga_scanout at full 800x600 timing and at a reduced
//            timing that wraps frames quickly. Colour bars checked when VGA_TESTPAT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_scanout;

    localparam int P_HV[2] = '{800, 40};
    localparam int P_HF[2] = '{40, 4};
    localparam int P_HS[2] = '{128, 8};
    localparam int P_HB[2] = '{88, 4};
    localparam int P_VV[2] = '{600, 12};
    localparam int P_VF[2] = '{1, 1};
    localparam int P_VS[2] = '{4, 4};
    localparam int P_VB[2] = '{23, 3};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        test_mode = 1'b0;
    logic [11:0] datin0 = '0;
    logic [11:0] datin1 = '0;
    wire         read0, read1, wr0, wr1, hs0, hs1, vs0, vs1, fs0, fs1;
    wire  [7:0]  x0, y0, x1, y1;
    wire  [11:0] rgb0, rgb1;

    always #5 clk = ~clk;

    vga_scanout dut_full (
        .clk(clk), .rst_n(rst_n),
`ifdef VGA_TESTPAT_EN
        .test_mode(test_mode),
`endif
        .read(read0), .X(x0), .Y(y0), .DATIN(datin0), .wr_ok(wr0),
        .rgb(rgb0), .hsync(hs0), .vsync(vs0), .frame_start(fs0)
    );

    vga_scanout #(
        .H_VIS(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(12), .V_FP(1), .V_SYNC(4), .V_BP(3)
    ) dut_small (
        .clk(clk), .rst_n(rst_n),
`ifdef VGA_TESTPAT_EN
        .test_mode(test_mode),
`endif
        .read(read1), .X(x1), .Y(y1), .DATIN(datin1), .wr_ok(wr1),
        .rgb(rgb1), .hsync(hs1), .vsync(vs1), .frame_start(fs1)
    );

    int          errors = 0;
    int          checks = 0;
    int          t = 0;
    int          ph = 0;
    logic [11:0] mem [0:149][0:199];
    logic [7:0]  ex_x [2];
    logic [7:0]  ex_y [2];
    bit          tm_frame [2];
    bit          tmh [2][3];
    bit          tm_prev;
    logic [11:0] pend [2];
    int          rd_cnt, hs_first, hs_len, vs_first, vs_len, fs_cnt;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", nm, t, act, exp);
        end
    endtask

    function automatic logic [11:0] bar_rgb(input int h);
        int b;
        b = h / 100;
        return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
    endfunction

    task automatic reset_checks();
        chk("rst_read0", int'(read0), 0);   chk("rst_read1", int'(read1), 0);
        chk("rst_rgb0", int'(rgb0), 0);     chk("rst_rgb1", int'(rgb1), 0);
        chk("rst_hsync0", int'(hs0), 0);    chk("rst_vsync0", int'(vs0), 0);
        chk("rst_hsync1", int'(hs1), 0);    chk("rst_vsync1", int'(vs1), 0);
        chk("rst_fs0", int'(fs0), 0);       chk("rst_fs1", int'(fs1), 0);
        chk("rst_x0", int'(x0), 0);         chk("rst_y0", int'(y0), 0);
        chk("rst_wr_ok0", int'(wr0), 1);
    endtask

    task automatic model_init();
        t = 0;
        tm_prev = test_mode;
        rd_cnt = 0; hs_first = -1; hs_len = 0; vs_first = -1; vs_len = 0; fs_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            ex_x[i] = '0; ex_y[i] = '0; tm_frame[i] = 1'b0; pend[i] = '0;
            for (int k = 0; k < 3; k++) tmh[i][k] = 1'b0;
        end
    endtask

    // Expected behaviour from screen position arithmetic, two-clock pin latency.
    task automatic check_cycle(input int i);
        int ht, vt, h, v, h2, v2;
        bit vis, e_rd, e_hs, e_vs, e_fs;
        logic [11:0] e_rgb;
        logic a_rd, a_wr, a_hs, a_vs, a_fs;
        logic [7:0] a_x, a_y;
        logic [11:0] a_rgb;
        if (i == 0) begin
            a_rd = read0; a_wr = wr0; a_hs = hs0; a_vs = vs0; a_fs = fs0;
            a_x = x0; a_y = y0; a_rgb = rgb0;
        end else begin
            a_rd = read1; a_wr = wr1; a_hs = hs1; a_vs = vs1; a_fs = fs1;
            a_x = x1; a_y = y1; a_rgb = rgb1;
        end
        ht = P_HV[i] + P_HF[i] + P_HS[i] + P_HB[i];
        vt = P_VV[i] + P_VF[i] + P_VS[i] + P_VB[i];
        h = t % ht;
        v = (t / ht) % vt;
        if (h == 0 && v == 0) tm_frame[i] = tm_prev;
        tmh[i][2] = tmh[i][1]; tmh[i][1] = tmh[i][0]; tmh[i][0] = tm_frame[i];
        vis  = (h < P_HV[i]) && (v < P_VV[i]);
        e_rd = vis && (h % 4 == 0) && !tm_frame[i];
        if (e_rd) begin
            ex_x[i] = 8'(h / 4);
            ex_y[i] = 8'(v / 4);
        end
        chk("read", int'(a_rd), int'(e_rd));
        chk("wr_ok", int'(a_wr), int'(!e_rd));
        chk("X", int'(a_x), int'(ex_x[i]));
        chk("Y", int'(a_y), int'(ex_y[i]));
        e_hs = 0; e_vs = 0; e_fs = 0; e_rgb = '0;
        if (t >= 2) begin
            h2 = (t - 2) % ht;
            v2 = ((t - 2) / ht) % vt;
            e_hs = (h2 >= P_HV[i] + P_HF[i]) && (h2 < P_HV[i] + P_HF[i] + P_HS[i]);
            e_vs = (v2 >= P_VV[i] + P_VF[i]) && (v2 < P_VV[i] + P_VF[i] + P_VS[i]);
            e_fs = (h2 == 0) && (v2 == 0);
            if (h2 < P_HV[i] && v2 < P_VV[i])
                e_rgb = tmh[i][2] ? bar_rgb(h2) : mem[v2 / 4][h2 / 4];
        end
        chk("hsync", int'(a_hs), int'(e_hs));
        chk("vsync", int'(a_vs), int'(e_vs));
        chk("frame_start", int'(a_fs), int'(e_fs));
        chk("rgb", int'(a_rgb), int'(e_rgb));
        pend[i] = (a_rd && a_x < 200 && a_y < 150) ? mem[a_y][a_x] : 12'($urandom);
    endtask

    task automatic literal_checks();
        if (ph == 1) begin
            if (t < 1056) rd_cnt += int'(read0);
            if (t < 1056 && hs0) begin
                if (hs_first < 0) hs_first = t;
                hs_len++;
            end
            if (t < 1500 && vs1) begin
                if (vs_first < 0) vs_first = t;
                vs_len++;
            end
            if (fs1 && t < 2300) fs_cnt++;
            if (t == 2 || t == 5) chk("lit_rgb_F00", int'(rgb0), 12'hF00);
            if (t == 6 || t == 9) chk("lit_rgb_0F0", int'(rgb0), 12'h0F0);
            if (t == 1056) begin
                chk("lit_line0_reads", rd_cnt, 200);
                chk("lit_hsync_start", hs_first, 842);
                chk("lit_hsync_len", hs_len, 128);
            end
            if (t == 4224) chk("lit_y_line4", int'(y0), 1);
            if (t == 7388) chk("lit_x_last_line7", int'(x0), 199);
            if (t == 1122) chk("lit_fs_second", int'(fs1), 1);
            if (t == 1500) begin
                chk("lit_vsync_start", vs_first, 730);
                chk("lit_vsync_len", vs_len, 224);
            end
            if (t == 2300) chk("lit_fs_count", fs_cnt, 3);
        end
`ifdef VGA_TESTPAT_EN
        if (ph == 2) begin
            rd_cnt += int'(read0);
            if (t == 2)   chk("lit_bar_px0", int'(rgb0), 12'h000);
            if (t == 102) chk("lit_bar_px100", int'(rgb0), 12'h00F);
            if (t == 801) chk("lit_bar_px799", int'(rgb0), 12'hFFF);
            if (t == 2999) chk("lit_tm_no_reads", rd_cnt, 0);
        end
`endif
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            datin0 = pend[0];
            datin1 = pend[1];
`ifdef VGA_TESTPAT_EN
            if (ph == 2 && t == 1500) test_mode = 1'b0;
`endif
            @(negedge clk);
            check_cycle(0);
            check_cycle(1);
            literal_checks();
            tm_prev = test_mode;
            t++;
        end
    endtask

    initial begin
        for (int r = 0; r < 150; r++)
            for (int c = 0; c < 200; c++)
                mem[r][c] = 12'($urandom);
        mem[0][0] = 12'hF00;
        mem[0][1] = 12'h0F0;

        rst_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            reset_checks();
        end
        model_init();
        rst_n = 1'b1;
        ph = 1;
        run_cycles(9000);

        // Asynchronous reset in the middle of a line.
        #2;
        rst_n = 1'b0;
`ifdef VGA_TESTPAT_EN
        test_mode = 1'b1;
`endif
        repeat (3) begin
            @(negedge clk);
            reset_checks();
        end
        model_init();
        rst_n = 1'b1;
        ph = 2;
        run_cycles(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
